// File: rtl/cdf_pkg.sv
// cdf_pkg: shared types and helpers for the inverse CDF 5/3 row stage.
//   COEF_W   signed coefficient width for low/high subbands
//   PIX_W    unsigned reconstructed pixel width
//   coef_t   signed coefficient, lift_t widened lifting accumulator
//   sat_pixel clamps a lifting result into the pixel range
package cdf_pkg;

    localparam int COEF_W = 10;
    localparam int PIX_W  = 8;

    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic        [PIX_W-1:0]  pixel_t;
    // Two guard bits cover the growth of the lifting sums.
    typedef logic signed [COEF_W+1:0] lift_t;

    typedef enum logic [1:0] {IDLE, PRIME, RUN} cdf_state_t;

    function automatic pixel_t sat_pixel(input lift_t v);
        if (v < lift_t'(0)) begin
            return '0;
        end else if (v > lift_t'((1 << PIX_W) - 1)) begin
            return '1;
        end else begin
            return v[PIX_W-1:0];
        end
    endfunction

endpackage

// File: rtl/cdf_to_row_if.sv
// cdf_to_row_if: coefficient input bus and pixel-pair output bus.
//   en        start pulse, low/high sampled on the same edge
//   low/high  K signed approximation / detail coefficients
//   out_*     reconstructed even/odd pixel pair and its index
//   out_valid pair valid, busy row in flight, done last pair
// master = producer of coefficients / consumer of pixels, slave = cdf_to_row.
interface cdf_to_row_if import cdf_pkg::*; #(
    parameter int LENGTH = 256
) ();

    localparam int K     = LENGTH / 2;
    localparam int IDX_W = $clog2(K);

    logic             en;
    coef_t            low  [K];
    coef_t            high [K];
    pixel_t           out_even;
    pixel_t           out_odd;
    logic [IDX_W-1:0] out_idx;
    logic             out_valid;
    logic             busy;
    logic             done;

    modport master (
        output en, low, high,
        input  out_even, out_odd, out_idx, out_valid, busy, done
    );

    modport slave (
        input  en, low, high,
        output out_even, out_odd, out_idx, out_valid, busy, done
    );

endinterface

// File: rtl/cdf53_inv_lift.sv
// cdf53_inv_lift: combinational inverse lifting step.
//   i_s_next  s[k+1]            i_d_cur  d[k]       i_d_next d[k+1]
//   i_e_cur   unsaturated e[k]
//   i_left    use i_d_next as the left detail neighbour (computes e[0])
//   i_right   right-edge mirror, e_next = e_cur
//   o_e_next  e[k+1] (unsaturated)  o_odd  o[k] (unsaturated)
module cdf53_inv_lift import cdf_pkg::*; (
    input  coef_t i_s_next,
    input  coef_t i_d_cur,
    input  coef_t i_d_next,
    input  lift_t i_e_cur,
    input  logic  i_left,
    input  logic  i_right,
    output lift_t o_e_next,
    output lift_t o_odd
);

    lift_t w_d_prev;
    lift_t w_d_next;
    lift_t w_update;

    always_comb begin
        w_d_next = lift_t'(i_d_next);
        w_d_prev = i_left ? w_d_next : lift_t'(i_d_cur);
        w_update = (w_d_prev + w_d_next + lift_t'(2)) >>> 2;
        o_e_next = i_right ? i_e_cur : (lift_t'(i_s_next) - w_update);
        o_odd    = lift_t'(i_d_cur) + ((i_e_cur + o_e_next) >>> 1);
    end

endmodule

// File: rtl/cdf_to_row.sv
// cdf_to_row: rebuilds one row of LENGTH pixels from CDF 5/3 subbands.
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    slave side of cdf_to_row_if (en/low/high in, pixel pairs out)
// Captures both subbands on en, spends one cycle deriving e[0], then emits
// one even/odd pixel pair per cycle with done on the last pair.
module cdf_to_row import cdf_pkg::*; #(
    parameter int LENGTH = 256
) (
    input  logic         clk,
    input  logic         reset,
    cdf_to_row_if.slave  bus
);

    localparam int K     = LENGTH / 2;
    localparam int IDX_W = $clog2(K);

    cdf_state_t       r_state;
    cdf_state_t       w_state_nxt;
    coef_t            r_low  [K];
    coef_t            r_high [K];
    lift_t            r_e_cur;
    logic [IDX_W-1:0] r_idx;
    pixel_t           r_out_even;
    pixel_t           r_out_odd;
    logic [IDX_W-1:0] r_out_idx;
    logic             r_valid;
    logic             r_busy;
    logic             r_done;

    logic             w_capture;
    logic             w_last;
    logic [IDX_W-1:0] w_kn;
    lift_t            w_e_next;
    lift_t            w_odd;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_last      = (r_state == RUN) && (r_idx == IDX_W'(K - 1));
        case (r_state)
            IDLE: begin
                if (bus.en) begin
                    w_state_nxt = PRIME;
                    w_capture   = 1'b1;
                end
            end
            PRIME:   w_state_nxt = RUN;
            RUN:     if (w_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // PRIME reuses the lifting step with s[0]/d[0] to derive e[0]; in RUN
    // the right neighbour index is clamped so the last pair reads in range.
    always_comb begin
        if (r_state == PRIME) begin
            w_kn = '0;
        end else if (r_idx == IDX_W'(K - 1)) begin
            w_kn = r_idx;
        end else begin
            w_kn = r_idx + 1'b1;
        end
    end

    cdf53_inv_lift u_lift (
        .i_s_next (r_low[w_kn]),
        .i_d_cur  (r_high[r_idx]),
        .i_d_next (r_high[w_kn]),
        .i_e_cur  (r_e_cur),
        .i_left   (r_state == PRIME),
        .i_right  (w_last),
        .o_e_next (w_e_next),
        .o_odd    (w_odd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < K; i++) begin
                r_low[i]  <= '0;
                r_high[i] <= '0;
            end
            r_e_cur    <= '0;
            r_idx      <= '0;
            r_out_even <= '0;
            r_out_odd  <= '0;
            r_out_idx  <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            // busy stays up through the cycle that shows done.
            r_busy  <= (w_state_nxt != IDLE) || w_last;
            if (w_capture) begin
                for (int i = 0; i < K; i++) begin
                    r_low[i]  <= bus.low[i];
                    r_high[i] <= bus.high[i];
                end
                r_idx <= '0;
            end
            if (r_state == PRIME) begin
                r_e_cur <= w_e_next;
            end
            if (r_state == RUN) begin
                r_out_even <= sat_pixel(r_e_cur);
                r_out_odd  <= sat_pixel(w_odd);
                r_out_idx  <= r_idx;
                r_valid    <= 1'b1;
                r_done     <= w_last;
                r_e_cur    <= w_e_next;
                r_idx      <= w_last ? '0 : r_idx + 1'b1;
            end
        end
    end

    assign bus.out_even  = r_out_even;
    assign bus.out_odd   = r_out_odd;
    assign bus.out_idx   = r_out_idx;
    assign bus.out_valid = r_valid;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule

// File: tb/tb_cdf_to_row.sv
// tb_cdf_to_row: self-checking bench for cdf_to_row. Expected pixels come
// from a direct array evaluation of the inverse lifting equations, or, for
// round-trip rows, from the original pixels fed through a forward transform.
module tb_cdf_to_row;
    import cdf_pkg::*;

    localparam int LENGTH = 256;
    localparam int K      = LENGTH / 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    cdf_to_row_if #(.LENGTH(LENGTH)) bus ();

    cdf_to_row #(.LENGTH(LENGTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    int cur_s [K];
    int cur_d [K];
    int nxt_s [K];
    int nxt_d [K];
    int exp_e [K];
    int exp_o [K];

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int clamp_pix(input int v);
        return (v < 0) ? 0 : ((v > 255) ? 255 : v);
    endfunction

    // Inverse 5/3 lifting on whole arrays, with both boundary extensions.
    task automatic model_inverse();
        int e [K+1];
        int dp;
        for (int k = 0; k < K; k++) begin
            dp   = (k == 0) ? cur_d[0] : cur_d[k-1];
            e[k] = cur_s[k] - ((dp + cur_d[k] + 2) >>> 2);
        end
        e[K] = e[K-1];
        for (int k = 0; k < K; k++) begin
            exp_e[k] = clamp_pix(e[k]);
            exp_o[k] = clamp_pix(cur_d[k] + ((e[k] + e[k+1]) >>> 1));
        end
    endtask

    // Random pixels -> forward 5/3 into cur_s/cur_d; expected = originals.
    task automatic make_round_trip();
        int x [2*K];
        int xr;
        int dp;
        for (int i = 0; i < 2*K; i++) x[i] = int'($urandom_range(255));
        for (int k = 0; k < K; k++) begin
            xr       = (k == K-1) ? x[2*k] : x[2*k+2];
            cur_d[k] = x[2*k+1] - ((x[2*k] + xr) >>> 1);
        end
        for (int k = 0; k < K; k++) begin
            dp       = (k == 0) ? cur_d[0] : cur_d[k-1];
            cur_s[k] = x[2*k] + ((dp + cur_d[k] + 2) >>> 2);
            exp_e[k] = x[2*k];
            exp_o[k] = x[2*k+1];
        end
    endtask

    task automatic rand_full(output int s [K], output int d [K]);
        for (int k = 0; k < K; k++) begin
            s[k] = int'($urandom_range(1023)) - 512;
            d[k] = int'($urandom_range(1023)) - 512;
        end
    endtask

    // which: 0 = current row, 1 = next row, 2 = random garbage
    task automatic load_bus(input int which);
        for (int k = 0; k < K; k++) begin
            if (which == 0) begin
                bus.low[k]  = coef_t'(cur_s[k]);
                bus.high[k] = coef_t'(cur_d[k]);
            end else if (which == 1) begin
                bus.low[k]  = coef_t'(nxt_s[k]);
                bus.high[k] = coef_t'(nxt_d[k]);
            end else begin
                bus.low[k]  = coef_t'($urandom);
                bus.high[k] = coef_t'($urandom);
            end
        end
    endtask

    // Checks for the cycle following edge c of a row (edge 0 = capture).
    task automatic check_cycle(input int c);
        int k;
        if (c < 2) begin
            chk($sformatf("valid_c%0d", c), int'(bus.out_valid), 0);
            chk($sformatf("done_c%0d", c), int'(bus.done), 0);
        end else begin
            k = c - 2;
            chk($sformatf("valid[%0d]", k), int'(bus.out_valid), 1);
            chk($sformatf("idx[%0d]", k), int'(bus.out_idx), k);
            chk($sformatf("even[%0d]", k), int'(bus.out_even), exp_e[k]);
            chk($sformatf("odd[%0d]", k), int'(bus.out_odd), exp_o[k]);
            chk($sformatf("done[%0d]", k), int'(bus.done), (k == K-1) ? 1 : 0);
        end
        chk($sformatf("busy_c%0d", c), int'(bus.busy), 1);
    endtask

    // started: en was already raised by the previous chained row.
    // chain: raise en on the done edge (ignored) and then one cycle later.
    task automatic run_row(input bit started, input bit chain);
        if (!started) begin
            @(negedge clk);
            load_bus(0);
            bus.en = 1'b1;
        end
        @(posedge clk);
        for (int c = 0; c <= K+1; c++) begin
            @(negedge clk);
            bus.en = 1'b0;
            if (c == 4) begin
                load_bus(2);
                bus.en = 1'b1;
            end
            if (chain && c == K) begin
                load_bus(2);
                bus.en = 1'b1;
            end
            if (chain && c == K+1) begin
                load_bus(1);
                bus.en = 1'b1;
            end
            check_cycle(c);
        end
        if (!chain) begin
            @(negedge clk);
            chk("idle_valid", int'(bus.out_valid), 0);
            chk("idle_done", int'(bus.done), 0);
            chk("idle_busy", int'(bus.busy), 0);
            chk("idle_idx_hold", int'(bus.out_idx), K-1);
        end
    endtask

    initial begin
        reset  = 1'b1;
        bus.en = 1'b0;
        for (int k = 0; k < K; k++) begin
            cur_s[k] = 0;
            cur_d[k] = 0;
        end
        load_bus(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_even", int'(bus.out_even), 0);
        chk("rst_odd", int'(bus.out_odd), 0);
        chk("rst_idx", int'(bus.out_idx), 0);
        chk("rst_valid", int'(bus.out_valid), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        reset = 1'b0;

        // Constant row.
        for (int k = 0; k < K; k++) begin
            cur_s[k] = 100;
            cur_d[k] = 0;
        end
        model_inverse();
        run_row(1'b0, 1'b0);

        // Ramp with right-edge detail: pixels 0..255.
        for (int k = 0; k < K; k++) begin
            cur_s[k] = 2 * k;
            cur_d[k] = (k == K-1) ? 1 : 0;
        end
        model_inverse();
        chk("ramp_model_last_odd", exp_o[K-1], 255);
        run_row(1'b0, 1'b0);

        // Saturation at both ends of the pixel range.
        for (int k = 0; k < K; k++) begin
            cur_s[k] = 0;
            cur_d[k] = 0;
        end
        cur_s[0] = -50;
        cur_s[1] = 400;
        model_inverse();
        run_row(1'b0, 1'b0);

        // Full-range random row chained back-to-back into another.
        rand_full(cur_s, cur_d);
        rand_full(nxt_s, nxt_d);
        model_inverse();
        run_row(1'b0, 1'b1);
        cur_s = nxt_s;
        cur_d = nxt_d;
        model_inverse();
        run_row(1'b1, 1'b0);

        // Round trips through a forward transform.
        for (int r = 0; r < 3; r++) begin
            make_round_trip();
            run_row(1'b0, 1'b0);
        end

        // Reset after pair 40, then a clean row.
        rand_full(cur_s, cur_d);
        model_inverse();
        @(negedge clk);
        load_bus(0);
        bus.en = 1'b1;
        @(posedge clk);
        for (int c = 0; c <= 42; c++) begin
            @(negedge clk);
            bus.en = 1'b0;
            check_cycle(c);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_valid", int'(bus.out_valid), 0);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_done", int'(bus.done), 0);
        chk("abort_even", int'(bus.out_even), 0);
        chk("abort_odd", int'(bus.out_odd), 0);
        chk("abort_idx", int'(bus.out_idx), 0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("abort_quiet_valid%0d", c), int'(bus.out_valid), 0);
            chk($sformatf("abort_quiet_done%0d", c), int'(bus.done), 0);
        end
        make_round_trip();
        run_row(1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/cdf_to_row.md
Name: cdf_to_row

Overview:
- Inverse of the row wavelet stage: rebuilds one image row of LENGTH 8-bit pixels from its CDF 5/3 (reversible integer lifting) low/high subbands.
- Coefficient arrays are captured on a single-cycle en pulse.
- Reconstructed pixels are emitted as even/odd pairs, one pair per cycle, with a done pulse on the last pair.
- Sits after the row_to_cdf stage in the round-trip/decoder path.

Parameters:
- LENGTH, 256, row length in pixels; even, >=4.
- PIX_W, 8, output pixel width (unsigned).
- COEF_W, 10, signed coefficient width for low and high inputs.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  start pulse; arrays sampled on the same edge.
- low  in  COEF_W x LENGTH/2  signed approximation coefficients s[k].
- high  in  COEF_W x LENGTH/2  signed detail coefficients d[k].
- out_even  out  PIX_W  reconstructed x[2k].
- out_odd  out  PIX_W  reconstructed x[2k+1].
- out_idx  out  $clog2(LENGTH/2)  pair index k.
- out_valid  out  1  out_even/out_odd/out_idx valid this cycle.
- busy  out  1  high from capture until the last pair.
- done  out  1  one-cycle pulse coincident with the last pair.

Behaviour:
- Reset: state=IDLE; all outputs 0; internal arrays and registers 0. Reset dominates every other input on the same edge, including mid-row: no further out_valid or done for the aborted row.
- Lifting, K=LENGTH/2, all arithmetic signed at COEF_W+2 bits, floor via arithmetic shift:
  - Even: e[k] = s[k] - ((d[k-1] + d[k] + 2) >>> 2), with d[-1] = d[0].
  - Odd: o[k] = d[k] + ((e[k] + e[k+1]) >>> 1), with e[K] = e[K-1] (symmetric extension).
  - Outputs saturate to [0, 2^PIX_W - 1]. The unsaturated e[k] is kept internally for the odd computation.
- FSM states: IDLE, PRIME, RUN.
  - IDLE: busy=0. en=1 captures low/high into internal arrays -> PRIME.
  - PRIME (1 cycle): compute e[0] into e_cur; k=0 -> RUN.
  - RUN: each cycle compute e[k+1] (or the mirror at k=K-1), then o[k]. Register out_even=sat(e_cur), out_odd=sat(o[k]), out_idx=k, out_valid=1. Then e_cur <= e[k+1], k++. At k=K-1 assert done and go to IDLE.
- Latency: en sampled at edge 0; pair k appears after edge k+2. The last pair and done appear after edge K+1 (edge 129 for the defaults). Throughput is one row per K+2 cycles.
- busy=1 from edge 0 through the cycle of done.
- en while busy (PRIME/RUN) is ignored. Arrays are not re-captured.
- en on the same edge that done is registered is also ignored. The next row is accepted one cycle later.
- Outside RUN: out_valid=0, done=0. out_even, out_odd and out_idx hold their last values.

Decomposition:
- Package cdf_pkg:
  - COEF_W and PIX_W defaults.
  - Typedefs coef_t (signed COEF_W), pixel_t (unsigned PIX_W), lift_t (signed COEF_W+2).
  - State enum cdf_state_t {IDLE, PRIME, RUN}.
  - Function sat_pixel(lift_t) -> pixel_t.
- Sub-module cdf53_inv_lift: combinational. Inputs s[k+1], d[k], d[k+1], e_cur. Outputs e_next and o_k, with the boundary-mirror selects passed in as control bits.
- cdf_to_row holds the FSM, coefficient capture arrays, index counter and output registers.

Test Plan:
- Constant row: all low=100, high=0, en pulse -> 128 pairs, every out_even=out_odd=100, out_idx 0..127, done together with out_idx=127 at edge 129.
- Ramp inverse: high[k]=0 for k<127, high[127]=1, low[k]=2k -> pixels 0,1,...,255 in order. The last pair is (254, 255), confirming the right-edge mirror.
- Saturation: low[0]=-50, low[1]=400, rest 0, high all 0 -> out_even[0]=0 and out_even[1]=255. The odd pixel between them uses unsaturated values: e[0]=-50, e[1]=400, so out_odd[0]=175.
- Busy protection and back-to-back: en re-pulsed at edge 5 with different arrays -> output unchanged from the first row. en at done+1 starts the second row cleanly, with its first pair 2 cycles later.
- Reset mid-row: reset asserted after pair 40 -> next cycle out_valid=0, busy=0, all outputs 0, no done. A subsequent en produces a complete correct row.
- Round trip: each row of image.bin goes through row_to_cdf, its low/high outputs feed cdf_to_row -> all 256 reconstructed pixels bit-exact to the originals for every row.
